// File: rtl/prog_loader_fsm.sv
// prog_loader_fsm: host-side loader/monitor for the 16-bit pipelined core.
// The host side uses a 4-phase req/ack handshake through pad synchronisers.
// Commands set the address registers and read or write the instruction or
// data memory, with the address auto-incremented after each memory access.
// A run/halt sequencer hands both memories to the core and counts run cycles.
// Optional build macro LOAD_CHECKSUM_EN adds a running checksum of host
// memory writes. It is read with command 0_1_x when wdata MSB=1, and it is
// cleared with command 1_1_x when wdata MSB=1.
`timescale 1ns/1ps
module prog_loader_fsm #(
  parameter int DATA_W  = 16,
  parameter int IADDR_W = 13,
  parameter int DADDR_W = 8,
  parameter int CNT_W   = 24,
  parameter logic [DATA_W-1:0] NOP_INSTR = 16'h2004
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_req,
  input  logic [2:0]         host_cmd,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic [DATA_W-1:0]  host_rdata,
  output logic               host_ack,
  input  logic               start_pad,
  output logic               done,
  output logic [CNT_W-1:0]   run_cycles,
  input  logic [IADDR_W-1:0] up_imem_addr,
  output logic [DATA_W-1:0]  up_instr,
  input  logic [DADDR_W-1:0] up_dmem_addr,
  input  logic [DATA_W-1:0]  up_wdata,
  input  logic               up_dwe,
  input  logic               up_hlt,
  output logic               imem_we_n,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  input  logic [DATA_W-1:0]  imem_rdata,
  output logic               dmem_we_n,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_RDWAIT = 3'd2,
    ST_ACK    = 3'd3,
    ST_RUN    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Command encoding {wr_rdb, addr_memb, instr_datab}
  localparam logic [2:0] CMD_SET_IADDR = 3'b111;
  localparam logic [2:0] CMD_SET_DADDR = 3'b110;
  localparam logic [2:0] CMD_WR_IMEM   = 3'b101;
  localparam logic [2:0] CMD_WR_DMEM   = 3'b100;
  localparam logic [2:0] CMD_RD_IADDR  = 3'b011;
  localparam logic [2:0] CMD_RD_DADDR  = 3'b010;
  localparam logic [2:0] CMD_RD_IMEM   = 3'b001;
  localparam logic [2:0] CMD_RD_DMEM   = 3'b000;

  localparam logic [IADDR_W-1:0] IADDR_ONE = IADDR_W'(1'b1);
  localparam logic [DADDR_W-1:0] DADDR_ONE = DADDR_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]         req_sync_q;
  logic [1:0]         start_sync_q;
  logic               req_prev_q;
  logic               req_s;
  logic               start_s;
  state_t             state_q;
  logic [2:0]         cmd_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  host_rdata_q;
  logic               host_ack_q;
  logic               done_q;
  logic [CNT_W-1:0]   run_cycles_q;
  logic [IADDR_W-1:0] iaddr_q;
  logic [DADDR_W-1:0] daddr_q;
  logic [IADDR_W-1:0] iaddr_inc_d;
  logic [DADDR_W-1:0] daddr_inc_d;
  logic [CNT_W-1:0]   cycles_inc_d;
`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0]  csum_q;
`endif

  assign req_s   = req_sync_q[1];
  assign start_s = start_sync_q[1];

  // Two-flop synchronisers for the pad inputs, plus the req_s history for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_sync_q   <= 2'b00;
      start_sync_q <= 2'b00;
      req_prev_q   <= 1'b0;
    end else begin
      req_sync_q   <= {req_sync_q[0], host_req};
      start_sync_q <= {start_sync_q[0], start_pad};
      req_prev_q   <= req_s;
    end
  end

  // Next values for the wrapping address registers and the saturating run counter
  always_comb begin
    iaddr_inc_d = iaddr_q + IADDR_ONE;
    daddr_inc_d = daddr_q + DADDR_ONE;
    if (run_cycles_q == CNT_MAX) begin
      cycles_inc_d = run_cycles_q;
    end else begin
      cycles_inc_d = run_cycles_q + CNT_ONE;
    end
  end

  // Main sequencer: host command execution, handshake and run/halt control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 3'b000;
      wdata_q      <= {DATA_W{1'b0}};
      host_rdata_q <= {DATA_W{1'b0}};
      host_ack_q   <= 1'b0;
      done_q       <= 1'b0;
      run_cycles_q <= {CNT_W{1'b0}};
      iaddr_q      <= {IADDR_W{1'b0}};
      daddr_q      <= {DADDR_W{1'b0}};
`ifdef LOAD_CHECKSUM_EN
      csum_q       <= {DATA_W{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A run request takes precedence and masks any host request
          if (start_s) begin
            run_cycles_q <= {CNT_W{1'b0}};
            state_q      <= ST_RUN;
          end else if (req_s && !req_prev_q) begin
            cmd_q   <= host_cmd;
            wdata_q <= host_wdata;
            state_q <= ST_EXEC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          case (cmd_q)
            CMD_SET_IADDR: begin
`ifdef LOAD_CHECKSUM_EN
              if (wdata_q[DATA_W-1]) begin
                csum_q <= {DATA_W{1'b0}};
              end else begin
                iaddr_q <= wdata_q[IADDR_W-1:0];
              end
`else
              iaddr_q <= wdata_q[IADDR_W-1:0];
`endif
              host_rdata_q <= wdata_q;
              host_ack_q   <= 1'b1;
              state_q      <= ST_ACK;
            end
            CMD_SET_DADDR: begin
`ifdef LOAD_CHECKSUM_EN
              if (wdata_q[DATA_W-1]) begin
                csum_q <= {DATA_W{1'b0}};
              end else begin
                daddr_q <= wdata_q[DADDR_W-1:0];
              end
`else
              daddr_q <= wdata_q[DADDR_W-1:0];
`endif
              host_rdata_q <= wdata_q;
              host_ack_q   <= 1'b1;
              state_q      <= ST_ACK;
            end
            CMD_WR_IMEM: begin
              // The write strobe is decoded from EXEC, so memory captures on this edge
              iaddr_q      <= iaddr_inc_d;
`ifdef LOAD_CHECKSUM_EN
              csum_q       <= csum_q + wdata_q;
`endif
              host_rdata_q <= wdata_q;
              host_ack_q   <= 1'b1;
              state_q      <= ST_ACK;
            end
            CMD_WR_DMEM: begin
              daddr_q      <= daddr_inc_d;
`ifdef LOAD_CHECKSUM_EN
              csum_q       <= csum_q + wdata_q;
`endif
              host_rdata_q <= wdata_q;
              host_ack_q   <= 1'b1;
              state_q      <= ST_ACK;
            end
            CMD_RD_IADDR: begin
`ifdef LOAD_CHECKSUM_EN
              if (wdata_q[DATA_W-1]) begin
                host_rdata_q <= csum_q;
              end else begin
                host_rdata_q <= DATA_W'(iaddr_q);
              end
`else
              host_rdata_q <= DATA_W'(iaddr_q);
`endif
              host_ack_q <= 1'b1;
              state_q    <= ST_ACK;
            end
            CMD_RD_DADDR: begin
`ifdef LOAD_CHECKSUM_EN
              if (wdata_q[DATA_W-1]) begin
                host_rdata_q <= csum_q;
              end else begin
                host_rdata_q <= DATA_W'(daddr_q);
              end
`else
              host_rdata_q <= DATA_W'(daddr_q);
`endif
              host_ack_q <= 1'b1;
              state_q    <= ST_ACK;
            end
            CMD_RD_IMEM, CMD_RD_DMEM: begin
              // Address is on the memory port now; data arrives next cycle
              state_q <= ST_RDWAIT;
            end
            default: begin
              host_ack_q <= 1'b1;
              state_q    <= ST_ACK;
            end
          endcase
        end
        ST_RDWAIT: begin
          if (cmd_q[0]) begin
            host_rdata_q <= imem_rdata;
            iaddr_q      <= iaddr_inc_d;
          end else begin
            host_rdata_q <= dmem_rdata;
            daddr_q      <= daddr_inc_d;
          end
          host_ack_q <= 1'b1;
          state_q    <= ST_ACK;
        end
        ST_ACK: begin
          // Hold the acknowledge until the host releases its request
          if (!req_s) begin
            host_ack_q <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            state_q <= ST_ACK;
          end
        end
        ST_RUN: begin
          run_cycles_q <= cycles_inc_d;
          // Dropping the run request aborts the run without reporting done
          if (!start_s) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (up_hlt) begin
            done_q  <= 1'b1;
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_HALT: begin
          if (!start_s) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_HALT;
          end
        end
        default: begin
          host_ack_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port muxes: the core owns both memories while running, the loader otherwise
  always_comb begin
    imem_wdata = wdata_q;
    imem_we_n  = 1'b1;
    if (state_q == ST_RUN) begin
      imem_addr  = up_imem_addr;
      dmem_addr  = up_dmem_addr;
      dmem_wdata = up_wdata;
      dmem_we_n  = ~up_dwe;
      up_instr   = imem_rdata;
    end else begin
      imem_addr  = iaddr_q;
      dmem_addr  = daddr_q;
      dmem_wdata = wdata_q;
      imem_we_n  = ~((state_q == ST_EXEC) && (cmd_q == CMD_WR_IMEM));
      dmem_we_n  = ~((state_q == ST_EXEC) && (cmd_q == CMD_WR_DMEM));
      up_instr   = NOP_INSTR;
    end
  end

  assign host_rdata = host_rdata_q;
  assign host_ack   = host_ack_q;
  assign done       = done_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_prog_loader_fsm.sv
// tb_prog_loader_fsm: drives prog_loader_fsm with directed and random host commands.
// Expected responses are pushed into a queue by the stimulus, and a separate
// monitor pops and compares them on each rising host_ack. Expected values
// come from a behavioural model of the loader built from queues and arrays.
`timescale 1ns/1ps
module tb_prog_loader_fsm;

  localparam int ISZ = 8192;
  localparam int DSZ = 256;
  localparam logic [15:0] NOP = 16'h2004;
`ifdef LOAD_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        host_req;
  logic [2:0]  host_cmd;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_ack;
  logic        start_pad;
  logic        done;
  logic [23:0] run_cycles;
  logic [12:0] up_imem_addr;
  logic [15:0] up_instr;
  logic [7:0]  up_dmem_addr;
  logic [15:0] up_wdata;
  logic        up_dwe;
  logic        up_hlt;
  logic        imem_we_n;
  logic [12:0] imem_addr;
  logic [15:0] imem_wdata;
  logic [15:0] imem_rdata;
  logic        dmem_we_n;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;

  prog_loader_fsm dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_cmd(host_cmd), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .start_pad(start_pad), .done(done), .run_cycles(run_cycles),
    .up_imem_addr(up_imem_addr), .up_instr(up_instr),
    .up_dmem_addr(up_dmem_addr), .up_wdata(up_wdata), .up_dwe(up_dwe), .up_hlt(up_hlt),
    .imem_we_n(imem_we_n), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .dmem_we_n(dmem_we_n), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] imem [0:ISZ-1];
  logic [15:0] dmem [0:DSZ-1];
  logic [15:0] ref_imem [0:ISZ-1];
  logic [15:0] ref_dmem [0:DSZ-1];
  int          ref_iaddr;
  int          ref_daddr;
  logic [15:0] ref_csum;
  logic [15:0] exp_q [$];

  function automatic logic [15:0] init_word(input int i, input bit is_imem);
    if (is_imem) return 16'((i * 37) ^ 16'hC3A5);
    else         return 16'((i * 101) + 16'h0F0F);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Synchronous 1-cycle-latency memories, preloaded with a known pattern during reset
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ISZ; i++) imem[i] <= init_word(i, 1'b1);
      for (int i = 0; i < DSZ; i++) dmem[i] <= init_word(i, 1'b0);
      imem_rdata <= 16'h0000;
      dmem_rdata <= 16'h0000;
    end else begin
      if (!imem_we_n) imem[imem_addr] <= imem_wdata;
      if (!dmem_we_n) dmem[dmem_addr] <= dmem_wdata;
      imem_rdata <= imem[imem_addr];
      dmem_rdata <= dmem[dmem_addr];
    end
  end

  // Monitor: each new acknowledge must match the oldest outstanding expectation
  initial begin : monitor
    logic prev_ack;
    logic [15:0] exp;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && host_ack === 1'b1 && prev_ack === 1'b0) begin
        check("ack_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("host_rdata", host_rdata, exp);
        end
      end
      prev_ack = host_ack;
    end
  end

  // One host transaction: update the model, queue the expected reply, run the handshake
  task automatic host_op(input logic [2:0] cmd, input logic [15:0] wd, input int hold);
    logic [15:0] exp;
    bit got;
    bit stayed;
    if (cmd[2]) begin
      exp = wd;
      if (cmd[1]) begin
        if (CSUM_EN && wd[15]) ref_csum = 16'h0000;
        else if (cmd[0]) ref_iaddr = int'(wd) % ISZ;
        else ref_daddr = int'(wd) % DSZ;
      end else begin
        if (cmd[0]) begin
          ref_imem[ref_iaddr] = wd;
          ref_iaddr = (ref_iaddr + 1) % ISZ;
        end else begin
          ref_dmem[ref_daddr] = wd;
          ref_daddr = (ref_daddr + 1) % DSZ;
        end
        ref_csum = ref_csum + wd;
      end
    end else if (cmd[1]) begin
      if (CSUM_EN && wd[15]) exp = ref_csum;
      else exp = cmd[0] ? 16'(ref_iaddr) : 16'(ref_daddr);
    end else begin
      if (cmd[0]) begin
        exp = ref_imem[ref_iaddr];
        ref_iaddr = (ref_iaddr + 1) % ISZ;
      end else begin
        exp = ref_dmem[ref_daddr];
        ref_daddr = (ref_daddr + 1) % DSZ;
      end
    end
    exp_q.push_back(exp);

    @(negedge clk);
    host_cmd   = cmd;
    host_wdata = wd;
    host_req   = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (host_ack) got = 1'b1;
    end
    check("ack_rise", got, 1'b1);
    if (hold > 0) begin
      stayed = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!host_ack) stayed = 1'b0;
      end
      check("ack_hold", stayed, 1'b1);
    end
    host_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 3 && !got; k++) begin
      @(negedge clk);
      if (!host_ack) got = 1'b1;
    end
    check("ack_fall", got, 1'b1);
    for (int k = 0; k < 10 && host_ack; k++) @(negedge clk);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Wait for run entry, observed as the core's store strobe reaching the data memory
  task automatic wait_run(output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (!dmem_we_n) got = 1'b1;
    end
    check("run_entry", got, 1'b1);
  endtask

  // Run that ends by core halt n cycles after entry
  task automatic run_halt(input int n);
    bit got;
    up_imem_addr = 13'($urandom_range(0, ISZ - 1));
    up_dmem_addr = 8'($urandom_range(0, DSZ - 1));
    up_wdata     = 16'($urandom);
    up_dwe       = 1'b1;
    up_hlt       = 1'b0;
    @(negedge clk);
    start_pad = 1'b1;
    wait_run(got);
    if (got) begin
      for (int c = 2; c <= n; c++) begin
        @(negedge clk);
        if (c == n / 2) begin
          check("run_up_instr", up_instr, ref_imem[up_imem_addr]);
          check("run_imem_we_n", imem_we_n, 1'b1);
          check("run_done_low", done, 1'b0);
        end
      end
      up_hlt = 1'b1;
      @(negedge clk);
      up_hlt = 1'b0;
      up_dwe = 1'b0;
      ref_dmem[up_dmem_addr] = up_wdata;
      check("halt_done", done, 1'b1);
      check("halt_run_cycles", run_cycles, 32'(n));
      check("halt_up_instr", up_instr, NOP);
      check("halt_dmem_we_n", dmem_we_n, 1'b1);
      repeat (5) @(negedge clk);
      check("halt_frozen", run_cycles, 32'(n));
    end
    up_dwe = 1'b0;
    start_pad = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      if (!done) got = 1'b0 | 1'b1;
    end
    check("done_clear", done, 1'b0);
    check("cycles_held", run_cycles, 32'(n));
  endtask

  // Run aborted by dropping start after k cycles; start_s falls two cycles later
  task automatic run_abort(input int k);
    bit got;
    up_dmem_addr = 8'($urandom_range(0, DSZ - 1));
    up_wdata     = 16'($urandom);
    up_dwe       = 1'b1;
    @(negedge clk);
    start_pad = 1'b1;
    wait_run(got);
    if (got) begin
      for (int c = 2; c <= k; c++) @(negedge clk);
      start_pad = 1'b0;
      repeat (3) @(negedge clk);
      ref_dmem[up_dmem_addr] = up_wdata;
      check("abort_cycles", run_cycles, 32'(k + 2));
      check("abort_done", done, 1'b0);
      check("abort_dmem_we_n", dmem_we_n, 1'b1);
    end
    up_dwe = 1'b0;
    start_pad = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [2:0]  cmd;
    logic [15:0] wd;
    int bad;
    reset = 1'b0;
    host_req = 1'b0; host_cmd = 3'b000; host_wdata = 16'h0000;
    start_pad = 1'b0;
    up_imem_addr = 13'h0000; up_dmem_addr = 8'h00; up_wdata = 16'h0000;
    up_dwe = 1'b0; up_hlt = 1'b0;
    for (int i = 0; i < ISZ; i++) ref_imem[i] = init_word(i, 1'b1);
    for (int i = 0; i < DSZ; i++) ref_dmem[i] = init_word(i, 1'b0);
    ref_iaddr = 0;
    ref_daddr = 0;
    ref_csum  = 16'h0000;

    repeat (3) @(negedge clk);
    check("rst_host_ack", host_ack, 1'b0);
    check("rst_host_rdata", host_rdata, 16'h0000);
    check("rst_done", done, 1'b0);
    check("rst_run_cycles", run_cycles, 24'h000000);
    check("rst_imem_we_n", imem_we_n, 1'b1);
    check("rst_dmem_we_n", dmem_we_n, 1'b1);
    check("rst_up_instr", up_instr, NOP);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_up_instr", up_instr, NOP);

    // Instruction load with auto-increment
    host_op(3'b111, 16'h0005, 0);
    host_op(3'b101, 16'h1234, 0);
    host_op(3'b101, 16'hABCD, 0);
    check("imem_5", imem[5], 16'h1234);
    check("imem_6", imem[6], 16'hABCD);
    host_op(3'b011, 16'h0000, 0);

    // Data address wrap
    host_op(3'b110, 16'h00FF, 0);
    host_op(3'b100, 16'h5555, 0);
    check("dmem_ff", dmem[255], 16'h5555);
    host_op(3'b010, 16'h0000, 0);

    // Memory read with post-increment
    host_op(3'b111, 16'h0005, 0);
    host_op(3'b001, 16'h0000, 0);
    host_op(3'b011, 16'h0000, 0);
    host_op(3'b000, 16'h0000, 0);

    // Long request hold gives one access only
    host_op(3'b101, 16'h7E57, 20);
    host_op(3'b011, 16'h0000, 0);

    run_halt(100);
    host_op(3'b010, 16'h0000, 0);

`ifdef LOAD_CHECKSUM_EN
    host_op(3'b110, 16'h8000, 0);
    host_op(3'b110, 16'h0010, 0);
    host_op(3'b100, 16'h0001, 0);
    host_op(3'b100, 16'hFFFF, 0);
    host_op(3'b010, 16'h8000, 0);
    host_op(3'b101, 16'h0042, 0);
    host_op(3'b110, 16'h8000, 0);
    host_op(3'b011, 16'h8000, 0);
    host_op(3'b010, 16'h0000, 0);
`endif

    run_abort(int'($urandom_range(5, 30)));

    for (int r = 0; r < 80; r++) begin
      cmd = 3'($urandom_range(0, 7));
      wd  = 16'($urandom);
      if (cmd[2:1] == 2'b11) wd = {wd[15], 11'h000, wd[3:0]};
      host_op(cmd, wd, int'($urandom_range(0, 2)));
    end

    run_halt(int'($urandom_range(10, 40)));
    host_op(3'b001, 16'h0000, 0);

    repeat (5) @(negedge clk);
    bad = 0;
    for (int i = 0; i < ISZ; i++) if (imem[i] !== ref_imem[i]) bad++;
    check("imem_contents", bad, 0);
    bad = 0;
    for (int i = 0; i < DSZ; i++) if (dmem[i] !== ref_dmem[i]) bad++;
    check("dmem_contents", bad, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader_fsm.md
Name: prog_loader_fsm

Overview:
Parametrised host-side loader/monitor between the chip pads and the 16-bit pipelined processor's instruction and data memories. It replaces the free-running, level-decoded load path with a synchronised 4-phase req/ack handshake and auto-increment on access only. It adds a memory read-latency wait, run/halt sequencing with a cycle counter, and pad-input synchronisers. It sits between the pad/LA glue and the processor core; the memories are synchronous with 1-cycle read latency.

Parameters:
DATA_W, 16, width of instruction words, data words and host data bus
IADDR_W, 13, instruction memory address width
DADDR_W, 8, data memory address width
CNT_W, 24, run-cycle counter width
NOP_INSTR, 16'h2004, instruction driven to the core while not running

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
host_req  input  1  host request level from pad, asynchronous to clk
host_cmd  input  3  {wr_rdb, addr_memb, instr_datab}, stable while host_req=1
host_wdata  input  DATA_W  host write data, stable while host_req=1
host_rdata  output  DATA_W  response data, valid while host_ack=1
host_ack  output  1  handshake acknowledge
start_pad  input  1  run request from pad, asynchronous
done  output  1  processor halted after a run
run_cycles  output  CNT_W  clk count from run entry to halt
up_imem_addr  input  IADDR_W  core instruction fetch address
up_instr  output  DATA_W  instruction to core
up_dmem_addr  input  DADDR_W  core data address
up_wdata  input  DATA_W  core store data
up_dwe  input  1  core store enable, active-high
up_hlt  input  1  core halt flag
imem_we_n / imem_addr / imem_wdata / imem_rdata  out/out/out/in  1/IADDR_W/DATA_W/DATA_W  instruction memory port
dmem_we_n / dmem_addr / dmem_wdata / dmem_rdata  out/out/out/in  1/DADDR_W/DATA_W/DATA_W  data memory port

Behaviour:
- host_req and start_pad pass through 2-flop synchronisers (reset 0). req_s and start_s denote the synchronised versions.
- Reset: state IDLE, iaddr_reg=0, daddr_reg=0, host_ack=0, host_rdata=0, done=0, run_cycles=0, imem_we_n=1, dmem_we_n=1.
- States: IDLE, EXEC, RDWAIT, ACK, RUN, HALT.
- IDLE:
  - A rising edge of req_s latches host_cmd and host_wdata, then goes to EXEC.
  - start_s=1 goes to RUN and clears run_cycles. A host request is ignored while start_s=1.
- EXEC, one cycle, actions per command:
  - 1_1_1: iaddr_reg <= wdata[IADDR_W-1:0]; go to ACK.
  - 1_1_0: daddr_reg <= wdata[DADDR_W-1:0]; go to ACK.
  - 1_0_1: imem_we_n=0 at iaddr_reg; iaddr_reg++; go to ACK.
  - 1_0_0: dmem_we_n=0 at daddr_reg; daddr_reg++; go to ACK.
  - 0_1_x: rdata <= zero-extended iaddr_reg (x=1) or daddr_reg (x=0); go to ACK.
  - 0_0_x: memory address driven; go to RDWAIT.
- RDWAIT, one cycle: capture imem_rdata or dmem_rdata into host_rdata, then post-increment the selected address register. Go to ACK.
- Write commands: host_rdata echoes wdata.
- ACK: host_ack=1. When req_s=0, drop host_ack and go to IDLE. Exactly one access per req pulse.
- Address registers wrap modulo 2^width; e.g. 2^IADDR_W-1 increments to 0.
- RUN:
  - Memory address, write-data and we_n muxes select the core ports; dmem_we_n = ~up_dwe; imem_we_n=1; up_instr=imem_rdata.
  - run_cycles increments every clk and saturates at all-ones.
  - up_hlt=1 goes to HALT.
  - start_s=0 goes to IDLE with done=0.
- HALT: done=1, run_cycles frozen, up_instr=NOP_INSTR. start_s=0 goes to IDLE and clears done; run_cycles is held.
- In every state except RUN, up_instr=NOP_INSTR.
- Run entry from IDLE only; a run request during EXEC/RDWAIT/ACK is deferred until IDLE.
- Reset mid-operation returns to IDLE immediately; any in-flight write is abandoned (we_n forced 1 asynchronously).

Optional Feature:
LOAD_CHECKSUM_EN:
- Defined:
  - A DATA_W-bit checksum register (reset 0) adds wdata modulo 2^DATA_W on every host memory write (1_0_x).
  - Checksum reads as host_rdata on command 0_1_x when wdata[DATA_W-1]=1.
  - A host register write to either address register (1_1_x) with wdata[DATA_W-1]=1 clears the checksum; the address register is not loaded.
- Undefined: no checksum logic; bit DATA_W-1 of wdata is ignored beyond address truncation.

Test Plan:
- Load iaddr=0x0005, write 0x1234 then 0xABCD -> imem[5]=0x1234, imem[6]=0xABCD; read iaddr returns 0x0007; each write produces exactly one ack.
- daddr=0xFF, write 0x5555 -> dmem[0xFF]=0x5555; daddr reads 0x0000 (wrap).
- Read imem at 5 after the load above -> host_rdata=0x1234 in ACK; iaddr becomes 6.
- start_pad=1, core asserts up_hlt 100 clk after RUN entry -> done=1, run_cycles=100, up_instr=0x2004 in HALT.
- Hold host_req high 20 clk -> single access, host_ack stays 1 until req falls, then 0 within 3 clk.
- With LOAD_CHECKSUM_EN, write 0x0001, 0xFFFF -> checksum reads 0x0000; clear via 1_1_0 with bit15 set -> 0, daddr unchanged.
